// File: rtl/fetch_stage.sv
// Instruction-fetch stage feeding the 128-bit IF/ID register.
// Owns the PC, issues one outstanding word request at a time to instruction
// memory, absorbs variable response latency, buffers one word across a
// downstream stall, and flushes on branch/jump redirects. The packet is
// all-zero whenever no valid instruction is present, so a downstream
// OR-reduction of the packet yields the valid bit.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         Clk,
  input  logic         Resetbar,
  input  logic         Stallbar,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [31:0]  imem_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic [127:0] fetch_packet
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request driven to memory, waiting for ready
    S_WAIT = 2'd1,  // request accepted, waiting for response
    S_HOLD = 2'd2   // response captured, waiting for the slot to free
  } state_t;

  state_t       r_state;
  logic [31:0]  r_pc;         // next address to request
  logic [31:0]  r_req_pc;     // address of the outstanding/buffered word
  logic [31:0]  r_buf;        // one-entry buffer for a word received under stall
  logic         r_drop;       // outstanding response belongs to a flushed path
  logic         r_req_valid;
  logic [127:0] r_packet;

  logic [31:0]  w_redirect_pc;
  logic [31:0]  w_next_pc;
  logic         w_slot_free;
  logic         w_accept;
  logic [127:0] w_rsp_pkt;
  logic [127:0] w_buf_pkt;

  // Redirect targets are forced word-aligned; pc+4 wraps naturally at 32 bits.
  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
  assign w_next_pc     = r_req_pc + 32'd4;
  // The slot can take a new word if downstream captures this edge or it holds a bubble.
  assign w_slot_free   = Stallbar || !r_packet[0];
  assign w_accept      = r_req_valid && imem_req_ready;
  assign w_rsp_pkt     = {r_req_pc, imem_rsp_data, w_next_pc, 31'h0, 1'b1};
  assign w_buf_pkt     = {r_req_pc, r_buf, w_next_pc, 31'h0, 1'b1};

  assign imem_req_valid = r_req_valid;
  assign imem_addr      = r_pc;
  assign fetch_packet   = r_packet;

  // Fetch FSM: PC, request handshake, response handling and the output slot.
  // NOTE: every state element here uses non-blocking assignment, so later
  // assignments in the same edge override the earlier defaults cleanly
  // and reads always see the pre-edge values.
  always_ff @(posedge Clk or negedge Resetbar) begin
    if (!Resetbar) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_buf       <= 32'h0;
      r_drop      <= 1'b0;
      r_req_valid <= 1'b0;
      r_packet    <= 128'h0;
    end else begin
      // Downstream captured the slot and nothing new arrives: emit a bubble.
      if (Stallbar) r_packet <= 128'h0;

      if (redirect_valid) begin
        // Flush has priority over stall and over any response this edge.
        r_packet <= 128'h0;
        r_pc     <= w_redirect_pc;
        case (r_state)
          S_REQ: begin
            if (w_accept) begin
              // Memory took the old address; its response must be discarded.
              r_state     <= S_WAIT;
              r_drop      <= 1'b1;
              r_req_valid <= 1'b0;
            end else begin
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              r_state     <= S_REQ;
              r_drop      <= 1'b0;
              r_req_valid <= 1'b1;
            end else begin
              r_drop <= 1'b1;
            end
          end
          default: begin
            // HOLD: buffered word is on the flushed path.
            r_state     <= S_REQ;
            r_req_valid <= 1'b1;
          end
        endcase
      end else begin
        case (r_state)
          S_REQ: begin
            r_req_valid <= 1'b1;
            if (w_accept) begin
              r_req_pc    <= r_pc;
              r_state     <= S_WAIT;
              r_req_valid <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rsp_valid) begin
              if (r_drop) begin
                r_drop      <= 1'b0;
                r_state     <= S_REQ;
                r_req_valid <= 1'b1;
              end else if (w_slot_free) begin
                r_packet    <= w_rsp_pkt;
                r_pc        <= w_next_pc;
                r_state     <= S_REQ;
                r_req_valid <= 1'b1;
              end else begin
                r_buf   <= imem_rsp_data;
                r_state <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (Stallbar) begin
              r_packet    <= w_buf_pkt;
              r_pc        <= w_next_pc;
              r_state     <= S_REQ;
              r_req_valid <= 1'b1;
            end
          end
          default: begin
            r_state     <= S_REQ;
            r_req_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A cycle-stepped driver plays both the
// downstream stage and a variable-latency instruction memory; expected request
// addresses and packets are queued as stimulus is issued and a negedge monitor
// pops and compares them whenever the DUT hands over a request or a new packet.
module tb_fetch_stage;

  logic         Clk;
  logic         Resetbar;
  logic         Stallbar;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [31:0]  imem_addr;
  logic         imem_rsp_valid;
  logic [31:0]  imem_rsp_data;
  logic [127:0] fetch_packet;

  fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
    .Clk            (Clk),
    .Resetbar       (Resetbar),
    .Stallbar       (Stallbar),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_packet   (fetch_packet)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_vec = 0;
  int n_err = 0;

  logic [31:0]  addr_q[$];
  logic [127:0] pkt_q[$];
  logic [127:0] prev_pkt = 128'h0;

  // Memory model state.
  int          lat = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [127:0] pkt(input logic [31:0] pc);
    logic [31:0] pc4;
    pc4 = pc + 32'd4;
    return {pc, mem_word(pc), pc4, 31'h0, 1'b1};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: memory accepts on handshake and answers lat edges later.
  task automatic tick();
    logic        hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_addr;
    @(posedge Clk);
    #1;
    imem_rsp_valid = 1'b0;
    if (hs) begin
      mem_busy = 1'b1;
      mem_cnt  = lat;
      mem_addr = a;
    end
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(mem_addr);
        mem_busy       = 1'b0;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compares accepted requests and newly presented packets.
  always @(negedge Clk) begin
    if (imem_req_valid && imem_req_ready) begin
      if (addr_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
      end else begin
        check("req_addr", {96'h0, imem_addr}, {96'h0, addr_q.pop_front()});
      end
    end
    if (fetch_packet[0] && fetch_packet != prev_pkt) begin
      if (pkt_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pkt: got %h expected no packet", fetch_packet);
      end else begin
        check("packet", fetch_packet, pkt_q.pop_front());
      end
    end
    if (!fetch_packet[0]) check("bubble_all_zero", fetch_packet, 128'h0);
    prev_pkt = fetch_packet;
  end

  initial begin
    Resetbar       = 1'b0;
    Stallbar       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    lat            = 1;

    // 1. Reset state, then back-to-back fetch with 1-cycle memory.
    ticks(2);
    check("rst_packet", fetch_packet, 128'h0);
    check("rst_req_valid", {127'h0, imem_req_valid}, 128'h0);
    check("rst_addr", {96'h0, imem_addr}, {96'h0, 32'h100});
    addr_q.push_back(32'h100); addr_q.push_back(32'h104); addr_q.push_back(32'h108);
    pkt_q.push_back(pkt(32'h100)); pkt_q.push_back(pkt(32'h104)); pkt_q.push_back(pkt(32'h108));
    Resetbar = 1'b1;
    tick();
    check("first_req_valid", {127'h0, imem_req_valid}, 128'h1);
    ticks(3);
    check("bubble_between", fetch_packet, 128'h0);
    ticks(3);

    // 2. Stall for 5 cycles while a response arrives: buffered in HOLD.
    Stallbar = 1'b0;
    addr_q.push_back(32'h10C);
    ticks(5);
    check("hold_packet", fetch_packet, pkt(32'h108));
    check("hold_no_req", {127'h0, imem_req_valid}, 128'h0);
    Stallbar = 1'b1;
    addr_q.push_back(32'h110);
    pkt_q.push_back(pkt(32'h10C)); pkt_q.push_back(pkt(32'h110));
    tick();
    check("hold_release", fetch_packet, pkt(32'h10C));
    ticks(2);

    // 3. Redirect in WAIT with 3-cycle latency: flush, drop stale response.
    Stallbar = 1'b0;
    lat = 3;
    addr_q.push_back(32'h114);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_2003;
    tick();
    redirect_valid = 1'b0;
    Stallbar       = 1'b1;
    check("redirect_flush", fetch_packet, 128'h0);
    addr_q.push_back(32'h2000);
    pkt_q.push_back(pkt(32'h2000));
    ticks(2);
    check("redirect_addr", {96'h0, imem_addr}, {96'h0, 32'h2000});
    check("redirect_req_valid", {127'h0, imem_req_valid}, 128'h1);
    tick();
    imem_req_ready = 1'b0;
    ticks(3);

    // 4. Redirect on the same edge as the response: response dropped.
    imem_req_ready = 1'b1;
    lat = 2;
    addr_q.push_back(32'h2004);
    ticks(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3002;
    tick();
    redirect_valid = 1'b0;
    check("same_edge_addr", {96'h0, imem_addr}, {96'h0, 32'h3000});
    check("same_edge_packet", fetch_packet, 128'h0);
    addr_q.push_back(32'h3000);
    pkt_q.push_back(pkt(32'h3000));
    tick();
    imem_req_ready = 1'b0;
    ticks(2);

    // 5. Redirect in REQ without ready, then PC wrap at the top of memory.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    check("req_redirect_addr", {96'h0, imem_addr}, {96'h0, 32'hFFFF_FFFC});
    imem_req_ready = 1'b1;
    lat = 1;
    addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
    pkt_q.push_back(pkt(32'hFFFF_FFFC)); pkt_q.push_back(pkt(32'h0));
    ticks(2);
    check("wrap_pc_plus4", {96'h0, fetch_packet[63:32]}, 128'h0);
    check("wrap_next_addr", {96'h0, imem_addr}, 128'h0);
    tick();
    imem_req_ready = 1'b0;
    tick();

    // 4b. Redirect on the same edge the request is accepted: stale, dropped.
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_4000;
    addr_q.push_back(32'h4);
    tick();
    redirect_valid = 1'b0;
    tick();
    check("stale_accept_addr", {96'h0, imem_addr}, {96'h0, 32'h4000});
    check("stale_accept_packet", fetch_packet, 128'h0);
    addr_q.push_back(32'h4000);
    pkt_q.push_back(pkt(32'h4000));
    tick();
    imem_req_ready = 1'b0;
    tick();

    // 6. Asynchronous reset mid-WAIT; the late response must be ignored.
    Stallbar = 1'b0;
    imem_req_ready = 1'b1;
    lat = 3;
    addr_q.push_back(32'h4004);
    ticks(2);
    Resetbar = 1'b0;
    #1;
    check("async_rst_packet", fetch_packet, 128'h0);
    check("async_rst_req_valid", {127'h0, imem_req_valid}, 128'h0);
    check("async_rst_addr", {96'h0, imem_addr}, {96'h0, 32'h100});
    tick();
    Resetbar = 1'b1;
    Stallbar = 1'b1;
    lat = 1;
    addr_q.push_back(32'h100);
    pkt_q.push_back(pkt(32'h100));
    tick();
    check("post_rst_req_valid", {127'h0, imem_req_valid}, 128'h1);
    check("post_rst_packet", fetch_packet, 128'h0);
    tick();
    imem_req_ready = 1'b0;
    ticks(3);

    check("addr_q_drained", 128'(addr_q.size()), 128'h0);
    check("pkt_q_drained", 128'(pkt_q.size()), 128'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
